// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with a show-ahead byte FIFO.
// RXD is synchronised, deserialised by a mid-bit sampling FSM, and good
// bytes are queued for a valid/ready consumer. Stop-bit errors and
// full-FIFO drops are reported as single-cycle pulses.
//
//   state | meaning
//   IDLE  | line idle, waiting for rxs to fall
//   START | timing half a bit to re-check the start bit at its centre
//   DATA  | sampling 8 data bits LSB-first at bit centres
//   STOP  | sampling the stop bit; push or flag, then back to IDLE

module uart_rx_buffered #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          RXD,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [1:0] sync;
    logic       rxs;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RXD};
        end
    end

    assign rxs = sync[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t     state;
    logic [CW-1:0] cyc_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    logic          stop_sample;
    logic          push;
    logic          pop;
    logic          full;

    // The stop-bit sample edge is also the FIFO write edge, so the byte is
    // visible on the very next cycle without an extra staging register.
    assign stop_sample = (state == STOP) && (cyc_cnt == BIT_END);
    assign push        = stop_sample && rxs;

    // Frame deserialiser: start validation, data shifting and stop check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        cyc_cnt <= '0;
                    end
                end
                START: begin
                    if (cyc_cnt == HALF_END) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        // A line that is high again at mid-start was a glitch.
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cyc_cnt == BIT_END) begin
                        cyc_cnt   <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cyc_cnt == BIT_END) begin
                        // Leaving mid-stop-bit lets the next start edge be
                        // caught even with a short stop bit from the sender.
                        state     <= IDLE;
                        cyc_cnt   <= '0;
                        frame_err <= ~rxs;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;

    assign full    = (count == FULL_CNT);
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // still accepted on that cycle.
    assign wr_en   = push && (!full || pop);
    assign m_data  = mem[rd_ptr];
    assign level   = count;

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    // Pointer, occupancy and overrun bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: scoreboard bench for uart_rx_buffered.
// Runs the receiver at 16 clocks per bit; an expected-byte queue is filled
// as frames are driven and drained by a monitor on output handshakes.

module tb_uart_rx_buffered;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       reset_n;
    logic       RXD;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       frame_err;
    logic       overrun;

    int checks;
    int failures;
    int hs_cnt;
    int ferr_cnt;
    int ovr_cnt;
    logic prev_ferr;
    logic prev_ovr;
    logic [7:0] exp_q [$];

    uart_rx_buffered #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (62_500),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .RXD       (RXD),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: scoreboard compare on handshakes, flag pulse tracking.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                chk("ferr_width", 32'(prev_ferr), 32'd0);
            end
            if (overrun) begin
                ovr_cnt++;
                chk("ovr_width", 32'(prev_ovr), 32'd0);
            end
            prev_ferr = frame_err;
            prev_ovr  = overrun;
        end else begin
            prev_ferr = 1'b0;
            prev_ovr  = 1'b0;
        end
    end

    // Drives one 10-bit frame starting just after a rising edge. When
    // lvl_before >= 0 the cycles around the stop sample are checked exactly.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit,
                               input int lvl_before, input int lvl_after,
                               input logic exp_ov, input logic pop_on_push);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int j = 0; j < 9; j++) begin
            RXD = bits[j];
            repeat (CPB) @(posedge clk);
            #1;
        end
        RXD = stop_bit;
        repeat (HALF + 2) @(posedge clk);
        #1;
        if (lvl_before >= 0) begin
            chk("level_pre", 32'(level), 32'(lvl_before));
            chk("ferr_pre", 32'(frame_err), 32'd0);
        end
        if (pop_on_push) m_ready = 1'b1;
        @(posedge clk);
        #1;
        if (pop_on_push) m_ready = 1'b0;
        if (lvl_before >= 0) begin
            chk("level_post", 32'(level), 32'(lvl_after));
            chk("ferr_post", 32'(frame_err), 32'(!stop_bit));
            chk("ovr_post", 32'(overrun), 32'(exp_ov));
        end
        repeat (CPB - HALF - 3) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        m_ready = 1'b1;
        for (int i = 0; i < 64 && level != 0; i++) @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk(tag, 32'(level), 32'd0);
        chk({tag, "_q"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int h0, f0, o0;
        checks = 0; failures = 0; hs_cnt = 0; ferr_cnt = 0; ovr_cnt = 0;
        prev_ferr = 1'b0; prev_ovr = 1'b0;
        RXD = 1'b1; m_ready = 1'b0; reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        idle(4);

        // Single frame, consumer stalled, then a one-cycle pop.
        exp_q.push_back(8'h55);
        drive_frame(8'h55, 1'b1, 0, 1, 1'b0, 1'b0);
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_head", 32'(m_data), 32'h55);
        idle(4);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("single_pop_valid", 32'(m_valid), 32'd0);
        chk("single_pop_level", 32'(level), 32'd0);

        // Back-to-back frames with no idle gap while draining.
        h0 = hs_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        m_ready = 1'b1;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h7D);
        drive_frame(8'h55, 1'b1, -1, 0, 1'b0, 1'b0);
        drive_frame(8'h7D, 1'b1, -1, 0, 1'b0, 1'b0);
        idle(CPB);
        m_ready = 1'b0;
        chk("b2b_handshakes", 32'(hs_cnt - h0), 32'd2);
        chk("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("b2b_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Framing error, then a good frame after idle is restored.
        f0 = ferr_cnt;
        drive_frame(8'hA3, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(3 * CPB);
        chk("ferr_level", 32'(level), 32'd0);
        chk("ferr_count", 32'(ferr_cnt - f0), 32'd1);
        exp_q.push_back(8'h12);
        drive_frame(8'h12, 1'b1, 0, 1, 1'b0, 1'b0);
        idle(2);
        drain("ferr_drain");

        // Glitch rejection: a short low pulse must not start a frame.
        f0 = ferr_cnt; o0 = ovr_cnt;
        RXD = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(3 * CPB);
        chk("glitch_level", 32'(level), 32'd0);
        chk("glitch_flags", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'd0);
        exp_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, 0, 1, 1'b0, 1'b0);
        idle(2);
        drain("glitch_drain");

        // Seventeen frames into a stalled FIFO: the last one overruns.
        o0 = ovr_cnt;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            drive_frame(8'(i), 1'b1, i, (i < 16) ? i + 1 : 16, (i == 16), 1'b0);
        end
        idle(2);
        chk("ovr_level", 32'(level), 32'd16);
        chk("ovr_count", 32'(ovr_cnt - o0), 32'd1);
        drain("ovr_drain");

        // Full FIFO with a pop on the push cycle: push is accepted.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            drive_frame(8'(8'h20 + i), 1'b1, i, i + 1, 1'b0, 1'b0);
        end
        o0 = ovr_cnt;
        exp_q.push_back(8'h30);
        drive_frame(8'h30, 1'b1, 16, 16, 1'b0, 1'b1);
        idle(2);
        chk("fullpop_ovr", 32'(ovr_cnt - o0), 32'd0);
        drain("fullpop_drain");

        // Reset during data bit 4 with three bytes queued.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'hA1 + i));
            drive_frame(8'(8'hA1 + i), 1'b1, i, i + 1, 1'b0, 1'b0);
        end
        idle(CPB);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'hF0, 1'b0};
            for (int j = 0; j < 10; j++) begin
                RXD = bits[j];
                for (int k = 0; k < CPB; k++) begin
                    if (j == 5 && k == 4) begin
                        reset_n = 1'b0;
                        #1;
                        chk("midrst_valid", 32'(m_valid), 32'd0);
                        chk("midrst_level", 32'(level), 32'd0);
                        exp_q.delete();
                    end
                    if (j == 5 && k == 9) reset_n = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        end
        idle(3 * CPB);
        chk("midrst_after_level", 32'(level), 32'd0);
        exp_q.push_back(8'h81);
        drive_frame(8'h81, 1'b1, 0, 1, 1'b0, 1'b0);
        idle(2);
        drain("midrst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
